// File: rtl/sorter_pkg.sv
// Shared types and default sizing for the comparison-free stream sorter.
package sorter_pkg;

   typedef enum logic {
      LOAD = 1'b0,
      SORT = 1'b1
   } state_e;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_ELEMENT_NUM = 16;

endpackage

// File: rtl/cf_sorter_stream_if.sv
// Stream bundle for the sorter: config, input beats, sorted output beats and busy.
interface cf_sorter_stream_if
   import sorter_pkg::*;
#(
   parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int LOG2_ELEMENT_NUM = $clog2(DEF_ELEMENT_NUM)
);
   logic                        cfg_desc;
   logic                        cfg_signed;
   logic                        in_valid;
   logic                        in_ready;
   logic [DATA_WIDTH-1:0]       in_data;
   logic                        in_last;
   logic                        out_valid;
   logic                        out_ready;
   logic [DATA_WIDTH-1:0]       out_data;
   logic [LOG2_ELEMENT_NUM-1:0] out_idx;
   logic                        out_last;
   logic                        busy;

   // Producer / consumer side
   modport master (
      output cfg_desc, cfg_signed, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last, busy
   );

   // Sorter side
   modport slave (
      input  cfg_desc, cfg_signed, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last, busy
   );
endinterface

// File: rtl/sort_bit_filter.sv
// One bit column of the candidate filter: keep candidates whose bit equals pref,
// unless none do, in which case the column does not discriminate.
module sort_bit_filter
   import sorter_pkg::*;
#(
   parameter int N = DEF_ELEMENT_NUM
) (
   input  logic [N-1:0] cand_i,
   input  logic [N-1:0] col_i,
   input  logic         pref_i,
   output logic [N-1:0] cand_o
);
   logic [N-1:0] match;

   assign match  = cand_i & ~(col_i ^ {N{pref_i}});
   assign cand_o = (|match) ? match : cand_i;
endmodule

// File: rtl/cf_sorter_stream.sv
// Comparison-free sorter: loads a batch into registers, then emits one element per
// cycle by filtering the bit-transposed memory MSB to LSB and taking the lowest index.
module cf_sorter_stream
   import sorter_pkg::*;
#(
   parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int ELEMENT_NUM      = DEF_ELEMENT_NUM,
   parameter int LOG2_ELEMENT_NUM = $clog2(ELEMENT_NUM)
) (
   input logic               clk,
   input logic               rst_n,
   cf_sorter_stream_if.slave bus
);
   // One extra bit so a full batch count (== ELEMENT_NUM) is representable.
   localparam int CNT_W = LOG2_ELEMENT_NUM + 1;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [CNT_W-1:0]            emit_cnt_q, emit_cnt_d;
   logic [ELEMENT_NUM-1:0]      remaining_q, remaining_d;
   logic                        desc_q, desc_d;
   logic                        signed_q, signed_d;
   logic [DATA_WIDTH-1:0]       mem_q [ELEMENT_NUM];
   logic [DATA_WIDTH-1:0]       mem_d [ELEMENT_NUM];

   logic [ELEMENT_NUM-1:0]      col        [DATA_WIDTH];
   logic [ELEMENT_NUM-1:0]      cand_chain [DATA_WIDTH+1];
   logic [LOG2_ELEMENT_NUM-1:0] sel;
   logic [LOG2_ELEMENT_NUM-1:0] wr_idx;
   logic                        in_fire;
   logic                        out_fire;
   logic                        is_last;

   assign cand_chain[DATA_WIDTH] = remaining_q;

   genvar gi, gj;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_col
         logic col_pref;

         for (gj = 0; gj < ELEMENT_NUM; gj++) begin : g_row
            assign col[gi][gj] = mem_q[gj][gi];
         end

         // The sign bit orders opposite to magnitude bits for two's complement.
         if (gi == DATA_WIDTH - 1) begin : g_msb
            assign col_pref = signed_q ? ~desc_q : desc_q;
         end else begin : g_mag
            assign col_pref = desc_q;
         end

         sort_bit_filter #(
            .N (ELEMENT_NUM)
         ) u_filter (
            .cand_i (cand_chain[gi+1]),
            .col_i  (col[gi]),
            .pref_i (col_pref),
            .cand_o (cand_chain[gi])
         );
      end
   endgenerate

   // Lowest surviving index wins, which keeps equal keys in load order.
   always_comb begin
      sel = '0;
      for (int i = ELEMENT_NUM - 1; i >= 0; i--) begin
         if (cand_chain[0][i]) sel = LOG2_ELEMENT_NUM'(i);
      end
   end

   assign wr_idx        = cnt_q[LOG2_ELEMENT_NUM-1:0];
   assign in_fire       = (state_q == LOAD) && bus.in_valid;
   assign out_fire      = (state_q == SORT) && bus.out_ready;
   assign is_last       = (state_q == SORT) && (emit_cnt_q == cnt_q - CNT_W'(1));

   assign bus.in_ready  = (state_q == LOAD);
   assign bus.out_valid = (state_q == SORT);
   assign bus.out_data  = (state_q == SORT) ? mem_q[sel] : '0;
   assign bus.out_idx   = (state_q == SORT) ? sel : '0;
   assign bus.out_last  = is_last;
   assign bus.busy      = (state_q == SORT) || (cnt_q != '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      emit_cnt_d  = emit_cnt_q;
      remaining_d = remaining_q;
      desc_d      = desc_q;
      signed_d    = signed_q;
      mem_d       = mem_q;

      case (state_q)
         LOAD: begin
            if (in_fire) begin
               mem_d[wr_idx]       = bus.in_data;
               remaining_d[wr_idx] = 1'b1;
               cnt_d               = cnt_q + CNT_W'(1);
               if (cnt_q == '0) begin
                  desc_d   = bus.cfg_desc;
                  signed_d = bus.cfg_signed;
               end
               if (bus.in_last || (cnt_q == CNT_W'(ELEMENT_NUM - 1))) begin
                  state_d = SORT;
               end
            end
         end
         SORT: begin
            if (out_fire) begin
               remaining_d[sel] = 1'b0;
               emit_cnt_d       = emit_cnt_q + CNT_W'(1);
               if (is_last) begin
                  state_d     = LOAD;
                  cnt_d       = '0;
                  emit_cnt_d  = '0;
                  remaining_d = '0;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         emit_cnt_q  <= '0;
         remaining_q <= '0;
         desc_q      <= 1'b0;
         signed_q    <= 1'b0;
         for (int i = 0; i < ELEMENT_NUM; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         emit_cnt_q  <= emit_cnt_d;
         remaining_q <= remaining_d;
         desc_q      <= desc_d;
         signed_q    <= signed_d;
         for (int i = 0; i < ELEMENT_NUM; i++) mem_q[i] <= mem_d[i];
      end
   end
endmodule

// File: tb/tb_cf_sorter_stream.sv
// Directed scoreboard bench for cf_sorter_stream with ELEMENT_NUM=4, DATA_WIDTH=8.
module tb_cf_sorter_stream;
   import sorter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   typedef struct {
      logic [7:0] d;
      logic [1:0] i;
      logic       l;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   cf_sorter_stream_if #(.DATA_WIDTH(8), .LOG2_ELEMENT_NUM(2)) sif ();

   cf_sorter_stream #(
      .DATA_WIDTH  (8),
      .ELEMENT_NUM (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic [1:0] i, input logic l);
      exp_t e;
      e.d = d;
      e.i = i;
      e.l = l;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per output handshake.
   always @(negedge clk) begin
      if (rst_n && sif.out_valid && sif.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got data %0h idx %0d, none expected",
                     sif.out_data, sif.out_idx);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data", 32'(sif.out_data), 32'(e.d));
            chk("out_idx",  32'(sif.out_idx),  32'(e.i));
            chk("out_last", 32'(sif.out_last), 32'(e.l));
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic last, input logic desc, input logic sgn);
      bit got = 0;
      sif.in_valid   = 1'b1;
      sif.in_data    = d;
      sif.in_last    = last;
      sif.cfg_desc   = desc;
      sif.cfg_signed = sgn;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (sif.in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck 0, required 1");
      end else begin
         @(posedge clk);
         #1;
      end
      sif.in_valid = 1'b0;
      sif.in_last  = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d outputs missing, required 0", exp_q.size());
         exp_q.delete();
      end
      #1;
      chk("idle_busy",      32'(sif.busy),      32'd0);
      chk("idle_in_ready",  32'(sif.in_ready),  32'd1);
      chk("idle_out_valid", 32'(sif.out_valid), 32'd0);
      chk("idle_out_data",  32'(sif.out_data),  32'd0);
   endtask

   initial begin
      sif.in_valid   = 1'b0;
      sif.in_data    = '0;
      sif.in_last    = 1'b0;
      sif.cfg_desc   = 1'b0;
      sif.cfg_signed = 1'b0;
      sif.out_ready  = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
      chk("rst_busy",      32'(sif.busy),      32'd0);
      chk("rst_out_data",  32'(sif.out_data),  32'd0);
      chk("rst_out_idx",   32'(sif.out_idx),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(sif.in_ready), 32'd1);

      // Descending unsigned, ties keep load order
      push_exp(8'd200, 2'd1, 1'b0);
      push_exp(8'd17,  2'd3, 1'b0);
      push_exp(8'd3,   2'd0, 1'b0);
      push_exp(8'd3,   2'd2, 1'b1);
      send(8'd3, 1'b0, 1'b1, 1'b0);
      chk("t1_busy_load", 32'(sif.busy), 32'd1);
      send(8'd200, 1'b0, 1'b0, 1'b0);
      send(8'd3,   1'b0, 1'b0, 1'b0);
      send(8'd17,  1'b1, 1'b0, 1'b0);
      chk("t1_latency_valid", 32'(sif.out_valid), 32'd1);
      chk("t1_in_ready_sort", 32'(sif.in_ready),  32'd0);
      drain();

      // Signed ascending
      push_exp(8'h80, 2'd0, 1'b0);
      push_exp(8'hFF, 2'd3, 1'b0);
      push_exp(8'h00, 2'd2, 1'b0);
      push_exp(8'h7F, 2'd1, 1'b1);
      send(8'h80, 1'b0, 1'b0, 1'b1);
      send(8'h7F, 1'b0, 1'b0, 1'b1);
      send(8'h00, 1'b0, 1'b0, 1'b1);
      send(8'hFF, 1'b1, 1'b0, 1'b1);
      drain();

      // Partial batch of two, descending
      push_exp(8'd9, 2'd1, 1'b0);
      push_exp(8'd5, 2'd0, 1'b1);
      send(8'd5, 1'b0, 1'b1, 1'b0);
      send(8'd9, 1'b1, 1'b1, 1'b0);
      chk("t3_in_ready_sort", 32'(sif.in_ready), 32'd0);
      drain();

      // Capacity-forced end of batch, then backpressure after the first output
      push_exp(8'd10, 2'd1, 1'b0);
      push_exp(8'd20, 2'd3, 1'b0);
      push_exp(8'd30, 2'd2, 1'b0);
      push_exp(8'd40, 2'd0, 1'b1);
      send(8'd40, 1'b0, 1'b0, 1'b0);
      send(8'd10, 1'b0, 1'b0, 1'b0);
      send(8'd30, 1'b0, 1'b0, 1'b0);
      send(8'd20, 1'b0, 1'b0, 1'b0);
      chk("t4_forced_sort", 32'(sif.out_valid), 32'd1);
      @(posedge clk);
      #1;
      sif.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_stall_valid", 32'(sif.out_valid), 32'd1);
         chk("t4_stall_data",  32'(sif.out_data),  32'd20);
         chk("t4_stall_idx",   32'(sif.out_idx),   32'd3);
         chk("t4_stall_last",  32'(sif.out_last),  32'd0);
      end
      @(posedge clk);
      #1;
      sif.out_ready = 1'b1;
      drain();

      // Back-to-back batches; config changes after the first beat are ignored
      push_exp(8'd2,  2'd2, 1'b0);
      push_exp(8'd7,  2'd0, 1'b0);
      push_exp(8'hF0, 2'd1, 1'b1);
      push_exp(8'd8,  2'd1, 1'b0);
      push_exp(8'd4,  2'd2, 1'b0);
      push_exp(8'd1,  2'd0, 1'b1);
      send(8'd7,  1'b0, 1'b0, 1'b0);
      send(8'hF0, 1'b0, 1'b1, 1'b1);
      send(8'd2,  1'b1, 1'b1, 1'b1);
      send(8'd1,  1'b0, 1'b1, 1'b0);
      send(8'd8,  1'b0, 1'b0, 1'b0);
      send(8'd4,  1'b1, 1'b0, 1'b0);
      drain();

      // Reset during SORT after two outputs
      push_exp(8'd4, 2'd3, 1'b0);
      push_exp(8'd3, 2'd2, 1'b0);
      send(8'd1, 1'b0, 1'b1, 1'b0);
      send(8'd2, 1'b0, 1'b1, 1'b0);
      send(8'd3, 1'b0, 1'b1, 1'b0);
      send(8'd4, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      chk("t6_two_outputs_seen", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", 32'(sif.out_valid), 32'd0);
      chk("t6_rst_busy",      32'(sif.busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_in_ready", 32'(sif.in_ready), 32'd1);
      push_exp(8'h03, 2'd1, 1'b0);
      push_exp(8'hFE, 2'd0, 1'b0);
      push_exp(8'h80, 2'd2, 1'b1);
      send(8'hFE, 1'b0, 1'b1, 1'b1);
      send(8'h03, 1'b0, 1'b1, 1'b1);
      send(8'h80, 1'b1, 1'b1, 1'b1);
      drain();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end
endmodule
